// File: rtl/perceptron_driver_if.sv
// perceptron_driver_if
//   Bundles the signals between perceptron_driver and its surroundings:
//   - pattern push port:   wr_valid, wr_data, wr_label, wr_ready
//   - perceptron classify: p_in, p_en, p_ready, p_out
//   - result/status:       res_valid, res_class, res_match, res_timeout,
//                          hit_cnt, total_cnt, busy
//   The master modport is the driver itself. The slave modport is whatever
//   feeds patterns in, reads results, and plays the perceptron.
interface perceptron_driver_if #(
  parameter int WIDTH = 25,
  parameter int CNT_W = 8
);
  logic             wr_valid;
  logic [WIDTH-1:0] wr_data;
  logic [1:0]       wr_label;
  logic             wr_ready;

  logic [WIDTH-1:0] p_in;
  logic             p_en;
  logic             p_ready;
  logic [1:0]       p_out;

  logic             res_valid;
  logic [1:0]       res_class;
  logic             res_match;
  logic             res_timeout;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] total_cnt;
  logic             busy;

  modport master (
    input  wr_valid, wr_data, wr_label, p_ready, p_out,
    output wr_ready, p_in, p_en,
    output res_valid, res_class, res_match, res_timeout,
    output hit_cnt, total_cnt, busy
  );

  modport slave (
    output wr_valid, wr_data, wr_label, p_ready, p_out,
    input  wr_ready, p_in, p_en,
    input  res_valid, res_class, res_match, res_timeout,
    input  hit_cnt, total_cnt, busy
  );
endinterface

// File: rtl/perceptron_driver.sv
// perceptron_driver
//   Initiator for a perceptron classify port. Patterns and their expected
//   labels are queued in a small FIFO. Each pattern is presented on p_in
//   with p_en held high. p_ready is ignored for the first MIN_WAIT cycles
//   so a stale ready from the previous pattern cannot be captured. The
//   class returned on p_out is then compared against the label, and
//   saturating hit/total counters are updated.
// Ports:
//   clk, rst : clock (rising edge) and asynchronous active-high reset
//   bus      : perceptron_driver_if.master carrying push, classify and
//              result/status signals
module perceptron_driver #(
  parameter int WIDTH    = 25,
  parameter int DEPTH    = 8,
  parameter int MIN_WAIT = 6,
  parameter int TIMEOUT  = 100,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  perceptron_driver_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [WW-1:0]    DRIVE_LAST = WW'(MIN_WAIT - 1);
  localparam logic [WW-1:0]    TO_LAST    = WW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [1:0]       label;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_DONE,
    S_GAP
  } state_t;

  // ---------------------------------------------------------------- FIFO
  // The pointers carry one extra wrap bit. Equal pointers mean empty.
  // Pointers that differ only in the wrap bit mean full.
  entry_t        mem [DEPTH];
  logic [AW:0]   wptr, rptr;
  logic          empty, full, push, pop;
  entry_t        head;
  state_t        state;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head  = mem[rptr[AW-1:0]];

  // The FSM takes the head only from IDLE. A pop frees a slot in the same
  // cycle, so a push into a full FIFO still succeeds while it pops.
  assign pop          = (state == S_IDLE) && !empty;
  assign bus.wr_ready = !full || pop;
  assign push         = bus.wr_valid && bus.wr_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= entry_t'{data: bus.wr_data, label: bus.wr_label};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // ----------------------------------------------------------------- FSM
  logic [WIDTH-1:0] p_in_q;
  logic             p_en_q;
  logic [1:0]       label_q;
  logic [WW-1:0]    wcnt;
  logic             res_valid_q, res_match_q, res_timeout_q;
  logic [1:0]       res_class_q;
  logic [CNT_W-1:0] hit_q, total_q;
  logic             match_now;

  // A match is only possible on a real ready. A timeout never counts as a hit.
  assign match_now = bus.p_ready && (bus.p_out == label_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      p_in_q        <= '0;
      p_en_q        <= 1'b0;
      label_q       <= '0;
      wcnt          <= '0;
      res_valid_q   <= 1'b0;
      res_class_q   <= '0;
      res_match_q   <= 1'b0;
      res_timeout_q <= 1'b0;
      hit_q         <= '0;
      total_q       <= '0;
    end else begin
      res_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          // p_in is written only here, so it holds through GAP/IDLE.
          if (!empty) begin
            p_in_q  <= head.data;
            label_q <= head.label;
            p_en_q  <= 1'b1;
            wcnt    <= '0;
            state   <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          // Stale-ready guard: p_ready is not looked at in this state.
          wcnt <= wcnt + 1'b1;
          if (wcnt == DRIVE_LAST) state <= S_WAIT;
        end
        S_WAIT: begin
          // The result registers, pulse and counters are loaded on the
          // way into DONE, so all of them are visible during the DONE cycle.
          if (bus.p_ready || (wcnt == TO_LAST)) begin
            res_class_q   <= bus.p_ready ? bus.p_out : 2'b11;
            res_match_q   <= match_now;
            res_timeout_q <= !bus.p_ready;
            res_valid_q   <= 1'b1;
            p_en_q        <= 1'b0;
            if (total_q != CNT_MAX)             total_q <= total_q + 1'b1;
            if (match_now && (hit_q != CNT_MAX)) hit_q  <= hit_q + 1'b1;
            state <= S_DONE;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_DONE:  state <= S_GAP;
        // The extra low cycle gives the perceptron a clean en falling edge.
        S_GAP:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.p_in        = p_in_q;
  assign bus.p_en        = p_en_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_class   = res_class_q;
  assign bus.res_match   = res_match_q;
  assign bus.res_timeout = res_timeout_q;
  assign bus.hit_cnt     = hit_q;
  assign bus.total_cnt   = total_q;
  assign bus.busy        = (state != S_IDLE) || !empty;

endmodule
